// File: rtl/mips_pkg.sv
// Shared MIPS core constants and the fetch-queue entry layout.
package mips_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // instr occupies [63:32], pcplus4 occupies [31:0]
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcplus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetchq_fifo.sv
// Generic DEPTH x W circular FIFO with push/pop/flush; flush overrides push and pop.
module fetchq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  logic do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush;

  assign rdata = mem[rptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, buffers {instr, pc+4} for IF/ID.
// Optional same-cycle bypass of an empty queue is enabled by defining FETCHQ_BYPASS_EN.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [XLEN-1:0]        imem_addr,
  output logic                   imem_req,
  input  logic [XLEN-1:0]        imem_instr,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   deq_valid,
  input  logic                   deq_ready,
  output logic [XLEN-1:0]        deq_instr,
  output logic [XLEN-1:0]        deq_pcplus4,
  output logic [$clog2(DEPTH):0] count
);

  logic [XLEN-1:0] fpc_q, fpc_plus4;
  fetch_entry_t    new_entry, head_entry, out_entry;
  logic            fifo_push, fifo_pop, fifo_empty, fifo_full, bypass;

  assign fpc_plus4 = fpc_q + 32'd4;
  assign new_entry = '{instr: imem_instr, pcplus4: fpc_plus4};

  assign imem_addr = fpc_q;
  assign imem_req  = !redirect && !fifo_full;

`ifdef FETCHQ_BYPASS_EN
  assign bypass = imem_req && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word taken by IF/ID in the same cycle never enters storage.
  assign fifo_push = imem_req && !(bypass && deq_ready);
  assign fifo_pop  = !redirect && !fifo_empty && deq_ready;

  assign deq_valid   = !redirect && (!fifo_empty || bypass);
  assign out_entry   = bypass ? new_entry : head_entry;
  assign deq_instr   = out_entry.instr;
  assign deq_pcplus4 = out_entry.pcplus4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc_q <= RESET_PC;
    end else if (redirect) begin
      fpc_q <= redirect_pc & ~32'h3;
    end else if (imem_req) begin
      fpc_q <= fpc_plus4;
    end
  end

  fetchq_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .wdata (new_entry),
    .rdata (head_entry),
    .count (count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build, DEPTH=4); imem word = addr ^ 32'hDEAD_0000.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_instr, redirect_pc, deq_instr, deq_pcplus4;
  logic        imem_req, redirect, deq_valid, deq_ready;
  logic [2:0]  count;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign imem_instr = imem_addr ^ 32'hDEAD_0000;

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_instr  (imem_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_instr   (deq_instr),
    .deq_pcplus4 (deq_pcplus4),
    .count       (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    deq_ready   = 1'b1;
    #2;
    chk("rst_valid", 32'(deq_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
    #10 reset = 1'b1;
    #1;
    // Cycle 0: first fetch, nothing dequeueable yet.
    chk("c0_addr", imem_addr, 32'h0);
    chk("c0_valid", 32'(deq_valid), 32'd0);
    step();
    chk("c1_valid", 32'(deq_valid), 32'd1);
    chk("c1_pc4", deq_pcplus4, 32'h4);
    chk("c1_instr", deq_instr, 32'hDEAD_0000);
    chk("c1_addr", imem_addr, 32'h4);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("stream_addr", imem_addr, 32'(4 * k));
      chk("stream_pc4", deq_pcplus4, 32'(4 * k));
      chk("stream_count", 32'(count), 32'd1);
    end

    // Back-pressure from a fresh reset.
    reset     = 1'b0;
    deq_ready = 1'b0;
    #1;
    chk("rst2_count", 32'(count), 32'd0);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) step();
    chk("full_count", 32'(count), 32'd4);
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_addr", imem_addr, 32'h10);
    chk("full_valid", 32'(deq_valid), 32'd1);
    chk("stall_head", deq_pcplus4, 32'h4);
    deq_ready = 1'b1;
    #1;
    chk("full_pop_req", 32'(imem_req), 32'd0);
    step();
    chk("pop1_pc4", deq_pcplus4, 32'h8);
    chk("pop1_count", 32'(count), 32'd3);
    chk("pop1_req", 32'(imem_req), 32'd1);
    chk("pop1_addr", imem_addr, 32'h10);
    step();
    chk("pop2_pc4", deq_pcplus4, 32'hC);
    chk("pop2_count", 32'(count), 32'd3);
    step();
    chk("pop3_pc4", deq_pcplus4, 32'h10);
    step();
    chk("pop4_pc4", deq_pcplus4, 32'h14);
    chk("pop4_instr", deq_instr, 32'hDEAD_0010);
    chk("pop4_addr", imem_addr, 32'h1C);
    chk("pop4_count", 32'(count), 32'd3);

    // Redirect with 3 entries held, deq_ready high and room to fetch.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    chk("redir_valid", 32'(deq_valid), 32'd0);
    chk("redir_req", 32'(imem_req), 32'd0);
    step();
    redirect = 1'b0;
    #1;
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_valid2", 32'(deq_valid), 32'd0);
    step();
    chk("redir_head_valid", 32'(deq_valid), 32'd1);
    chk("redir_head_pc4", deq_pcplus4, 32'h104);
    chk("redir_head_count", 32'(count), 32'd1);

    // Back-to-back redirects; the second one lands on the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect_pc = 32'hFFFF_FFFE;
    #1;
    chk("b2b_req", 32'(imem_req), 32'd0);
    step();
    redirect = 1'b0;
    #1;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_count0", 32'(count), 32'd0);
    step();
    chk("wrap_addr1", imem_addr, 32'h0);
    chk("wrap_pc4_0", deq_pcplus4, 32'h0);
    chk("wrap_instr0", deq_instr, 32'h2152_FFFC);
    step();
    chk("wrap_pc4_1", deq_pcplus4, 32'h4);
    chk("wrap_addr2", imem_addr, 32'h4);
    deq_ready = 1'b0;
    step();
    chk("pre_rst_count", 32'(count), 32'd2);
    chk("pre_rst_head", deq_pcplus4, 32'h4);

    // Asynchronous reset mid-stream, observed before the next edge.
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(deq_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_req", 32'(imem_req), 32'd1);
    #3 reset = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue for the pipelined MIPS core. It sits directly upstream of the IF/ID pipeline register and owns the fetch PC. It issues sequential fetch addresses to instruction memory and buffers up to DEPTH {instr, pc+4} pairs. It hands them to IF/ID through a valid/ready handshake. ID/EX hazard stalls back-pressure the queue instead of freezing the PC, and taken branches/jumps flush it through a redirect port.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_addr  out  32  fetch address to instruction memory (combinational-read, data returns same cycle)
- imem_req  out  1  fetch performed this cycle
- imem_instr  in  32  instruction word at imem_addr
- redirect  in  1  taken branch/jump resolved; flush and refetch
- redirect_pc  in  32  new fetch address; bits [1:0] ignored, forced 2'b00
- deq_valid  out  1  head entry available
- deq_ready  in  1  IF/ID accepts head (low on hazard stall)
- deq_instr  out  32  head instruction
- deq_pcplus4  out  32  head pc+4
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- State: fetch PC `fpc` (32b), read/write pointers ($clog2(DEPTH) bits, wrap modulo DEPTH), `count`, storage DEPTH×64b.
- imem_addr = fpc. imem_req = !redirect && (count < DEPTH).
- Push on imem_req: entry {imem_instr, fpc+4} is written at wptr. wptr increments. fpc <= fpc+4. Addition is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- deq_valid = !redirect && (count != 0). Pop on deq_valid && deq_ready: rptr increments.
- Simultaneous push and pop: count unchanged. A full queue does not fetch, even when popping that cycle. There is no full-and-pop fetch.
- Empty with deq_ready high: nothing is popped. deq_instr/deq_pcplus4 are don't-care while deq_valid is low.
- Redirect has the highest priority. On the next edge: count=0, rptr=wptr=0, fpc=redirect_pc & ~3. There is no push and no pop that cycle, regardless of deq_ready.
- Back-to-back redirects: the last one wins; no fetch occurs until redirect is low.
- Reset (asserted low, any time, asynchronous): fpc=RESET_PC, count=0, pointers=0. Hence deq_valid=0, imem_req=1, imem_addr=RESET_PC, count=0. Storage contents are not reset.

## Timing
- Fetch-to-dequeue latency without bypass: 1 cycle. A word fetched in cycle N appears at the head in cycle N+1 if the queue was empty.
- Redirect-to-fetch: redirect asserted in cycle N. redirect_pc is fetched in cycle N+1 and is dequeueable in N+2 (N+1 with bypass).
- Steady state with deq_ready held high: one instruction per cycle, count settles at 1 (0 with bypass).
- deq_ready may toggle freely. Head outputs stay stable while deq_valid && !deq_ready.

## Configuration
- FETCHQ_BYPASS_EN defined: when count==0 and imem_req, the fetched word is driven directly on deq_instr/deq_pcplus4 with deq_valid=1.
  - If deq_ready is high, the word is consumed without being written (count stays 0).
  - Otherwise it is written as normal.
- FETCHQ_BYPASS_EN undefined: no bypass. All words pass through storage (1-cycle latency).

## Structure
- Shared package mips_pkg: RESET_PC default, instruction/address width constant (32), fetch entry layout {instr[63:32], pcplus4[31:0]}.
- One sub-module fetchq_fifo: generic DEPTH×W storage with pointers, count, push/pop/flush. The fetch_queue top holds fpc, request, redirect and bypass logic.

## Test plan
- Reset release, deq_ready=1, imem returns addr-based words. Required:
  - imem_addr sequence 0x0, 0x4, 0x8, …
  - deq_pcplus4 sequence 0x4, 0x8, 0xC, … one per cycle
  - first deq_valid in cycle 1 (cycle 0 with bypass)
- deq_ready=0 for 10 cycles. count climbs to 4 (DEPTH=4) and imem_req drops to 0 with fpc=0x10. Raising deq_ready pops 0x4..0x10 in order, then fetching resumes at 0x10.
- Queue holding 3 entries, redirect=1 with redirect_pc=0x0000_0103. Required:
  - deq_valid=0 in the same cycle
  - next cycle: count=0, imem_addr=0x100
  - first dequeued pcplus4=0x104
- Redirect in the same cycle as deq_ready=1 and push conditions. No pop, no push, and count=0 after the edge.
- redirect_pc=0xFFFF_FFFC. Fetch addresses are 0xFFFF_FFFC then 0x0, with deq_pcplus4 0x0 then 0x4.
- reset pulsed low mid-stream with count=2. deq_valid and count go to 0 immediately (asynchronously), and imem_addr=RESET_PC before the next clock edge.
